// File: rtl/jump_issue_ctrl_pkg.sv
// Shared definitions for the jump/branch issue controller: FSM states,
// branch compare codes, default parameters and the redirect target helper.
package jump_issue_ctrl_pkg;

  localparam int TIMEOUT_DEFAULT = 8;
  localparam int TAG_W_DEFAULT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_WB      = 3'd4
  } state_t;

  // Compare codes follow the RISC-V branch funct3 encoding
  localparam logic [2:0] CMP_BEQ  = 3'b000;
  localparam logic [2:0] CMP_BNE  = 3'b001;
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BGE  = 3'b101;
  localparam logic [2:0] CMP_BLTU = 3'b110;
  localparam logic [2:0] CMP_BGEU = 3'b111;

  // JALR targets have bit 0 cleared
  function automatic logic [31:0] redirect_target(input logic jalr, input logic [31:0] pc_jump);
    return jalr ? {pc_jump[31:1], 1'b0} : pc_jump;
  endfunction

endpackage

// File: rtl/jump_issue_ctrl_if.sv
// Issue, FU, redirect and writeback bundle of the jump issue controller.
// master = controller side, slave = surrounding core (issue stage, FU, fetch, regfile).
interface jump_issue_ctrl_if
  import jump_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
);

  logic             issue_valid;
  logic             issue_ready;
  logic             issue_jalr;
  logic             issue_uncond;
  logic [2:0]       issue_cmp_ctrl;
  logic [31:0]      issue_rs1;
  logic [31:0]      issue_rs2;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_pc;
  logic [4:0]       issue_rd;
  logic [TAG_W-1:0] issue_tag;

  logic             fu_en;
  logic             fu_jalr;
  logic [2:0]       fu_cmp_ctrl;
  logic [31:0]      fu_rs1_data;
  logic [31:0]      fu_rs2_data;
  logic [31:0]      fu_imm;
  logic [31:0]      fu_pc;
  logic             fu_finish;
  logic [31:0]      fu_pc_jump;
  logic [31:0]      fu_pc_wb;
  logic             fu_cmp_res;

  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;

  modport master (
    input  issue_valid, issue_jalr, issue_uncond, issue_cmp_ctrl, issue_rs1, issue_rs2,
           issue_imm, issue_pc, issue_rd, issue_tag,
           fu_finish, fu_pc_jump, fu_pc_wb, fu_cmp_res, wb_ready,
    output issue_ready, fu_en, fu_jalr, fu_cmp_ctrl, fu_rs1_data, fu_rs2_data, fu_imm, fu_pc,
           redirect_valid, redirect_pc, wb_valid, wb_rd, wb_data, wb_tag
  );

  modport slave (
    output issue_valid, issue_jalr, issue_uncond, issue_cmp_ctrl, issue_rs1, issue_rs2,
           issue_imm, issue_pc, issue_rd, issue_tag,
           fu_finish, fu_pc_jump, fu_pc_wb, fu_cmp_res, wb_ready,
    input  issue_ready, fu_en, fu_jalr, fu_cmp_ctrl, fu_rs1_data, fu_rs2_data, fu_imm, fu_pc,
           redirect_valid, redirect_pc, wb_valid, wb_rd, wb_data, wb_tag
  );

endinterface

// File: rtl/jump_issue_ctrl.sv
// Issue-side controller for the jump/branch FU: one instruction in flight,
// FU enable pulse, finish timeout, fetch redirect pulse and held writeback request.
module jump_issue_ctrl
  import jump_issue_ctrl_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  jump_issue_ctrl_if.master bus,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;

  logic             op_jalr, op_uncond;
  logic [2:0]       op_cmp_ctrl;
  logic [31:0]      op_rs1, op_rs2, op_imm, op_pc;
  logic [4:0]       op_rd;
  logic [TAG_W-1:0] op_tag;
  logic [31:0]      res_pc_jump, res_pc_wb;
  logic             res_cmp_res;

  logic accept, need_wb, taken, timeout_hit;
  logic fu_en, redirect_valid, wb_valid;

  // issue_ready is gated by rst_n so every output reads 0 while reset is held
  assign bus.issue_ready = rst_n && (state == ST_IDLE) && !flush;
  assign accept          = bus.issue_valid && bus.issue_ready;
  assign need_wb         = op_uncond && (op_rd != 5'd0);
  assign taken           = op_uncond || res_cmp_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= (state == ST_WAIT) ? cnt + CNT_W'(1) : '0;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_jalr     <= 1'b0;
      op_uncond   <= 1'b0;
      op_cmp_ctrl <= '0;
      op_rs1      <= '0;
      op_rs2      <= '0;
      op_imm      <= '0;
      op_pc       <= '0;
      op_rd       <= '0;
      op_tag      <= '0;
      res_pc_jump <= '0;
      res_pc_wb   <= '0;
      res_cmp_res <= 1'b0;
    end else begin
      if (accept) begin
        op_jalr     <= bus.issue_jalr;
        op_uncond   <= bus.issue_uncond;
        op_cmp_ctrl <= bus.issue_cmp_ctrl;
        op_rs1      <= bus.issue_rs1;
        op_rs2      <= bus.issue_rs2;
        op_imm      <= bus.issue_imm;
        op_pc       <= bus.issue_pc;
        op_rd       <= bus.issue_rd;
        op_tag      <= bus.issue_tag;
      end
      if ((state == ST_WAIT) && bus.fu_finish && !flush) begin
        res_pc_jump <= bus.fu_pc_jump;
        res_pc_wb   <= bus.fu_pc_wb;
        res_cmp_res <= bus.fu_cmp_res;
      end
    end
  end

  // flush outranks everything: it kills the pulse of the current state and returns to IDLE
  always_comb begin
    state_next     = state;
    fu_en          = 1'b0;
    redirect_valid = 1'b0;
    wb_valid       = 1'b0;
    timeout_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          fu_en      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (bus.fu_finish) begin
          state_next = ST_RESOLVE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_RESOLVE: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          redirect_valid = taken;
          wb_valid       = need_wb;
          state_next     = (!need_wb || bus.wb_ready) ? ST_IDLE : ST_WB;
        end
      end
      ST_WB: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          wb_valid = 1'b1;
          if (bus.wb_ready) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.fu_en          = fu_en;
  assign bus.fu_jalr        = op_jalr;
  assign bus.fu_cmp_ctrl    = op_cmp_ctrl;
  assign bus.fu_rs1_data    = op_rs1;
  assign bus.fu_rs2_data    = op_rs2;
  assign bus.fu_imm         = op_imm;
  assign bus.fu_pc          = op_pc;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_target(op_jalr, res_pc_jump);
  assign bus.wb_valid       = wb_valid;
  assign bus.wb_rd          = op_rd;
  assign bus.wb_data        = res_pc_wb;
  assign bus.wb_tag         = op_tag;
  assign busy               = (state != ST_IDLE);

endmodule

// File: tb/tb_jump_issue_ctrl.sv
// Directed bench for jump_issue_ctrl with a behavioural FU that captures on
// fu_en and answers with fu_finish one cycle later.
module tb_jump_issue_ctrl;
  import jump_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  logic err_timeout;
  logic fu_mute;

  int checks = 0;
  int errors = 0;

  jump_issue_ctrl_if #(.TAG_W(4)) bus ();

  jump_issue_ctrl #(.TAG_W(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.master),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic cmp_eval(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    case (code)
      CMP_BEQ:  return a == b;
      CMP_BNE:  return a != b;
      CMP_BLT:  return $signed(a) < $signed(b);
      CMP_BGE:  return $signed(a) >= $signed(b);
      CMP_BLTU: return a < b;
      CMP_BGEU: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  // FU model; fu_mute withholds finish to provoke the timeout
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fu_finish  <= 1'b0;
      bus.fu_pc_jump <= '0;
      bus.fu_pc_wb   <= '0;
      bus.fu_cmp_res <= 1'b0;
    end else begin
      bus.fu_finish <= 1'b0;
      if (bus.fu_en && !fu_mute) begin
        bus.fu_finish  <= 1'b1;
        bus.fu_pc_jump <= (bus.fu_jalr ? bus.fu_rs1_data : bus.fu_pc) + bus.fu_imm;
        bus.fu_pc_wb   <= bus.fu_pc + 32'd4;
        bus.fu_cmp_res <= cmp_eval(bus.fu_cmp_ctrl, bus.fu_rs1_data, bus.fu_rs2_data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic jalr, input logic uncond, input logic [2:0] cmp,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] rd, input logic [3:0] tag);
    bus.issue_jalr     = jalr;
    bus.issue_uncond   = uncond;
    bus.issue_cmp_ctrl = cmp;
    bus.issue_rs1      = rs1;
    bus.issue_rs2      = rs2;
    bus.issue_imm      = imm;
    bus.issue_pc       = pc;
    bus.issue_rd       = rd;
    bus.issue_tag      = tag;
    bus.issue_valid    = 1'b1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    fu_mute = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_jalr = 1'b0;
    bus.issue_uncond = 1'b0;
    bus.issue_cmp_ctrl = '0;
    bus.issue_rs1 = '0;
    bus.issue_rs2 = '0;
    bus.issue_imm = '0;
    bus.issue_pc = '0;
    bus.issue_rd = '0;
    bus.issue_tag = '0;
    bus.wb_ready = 1'b1;

    #12;
    checkOutput("rst_fu_en", bus.fu_en, 0);
    checkOutput("rst_redirect", bus.redirect_valid, 0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 0);
    checkOutput("rst_wb_valid", bus.wb_valid, 0);
    checkOutput("rst_wb_data", bus.wb_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_timeout, 0);
    checkOutput("rst_issue_ready", bus.issue_ready, 0);
    rst_n = 1'b1;
    tick;
    $display("[TB] reset released");

    // JAL pc=0x100 imm=0x20 rd=1
    applyStimulus(1'b0, 1'b1, CMP_BEQ, 32'h0, 32'h0, 32'h20, 32'h100, 5'd1, 4'd3);
    checkOutput("jal_issue_ready", bus.issue_ready, 1);
    tick; bus.issue_valid = 1'b0;
    checkOutput("jal_fu_en", bus.fu_en, 1);
    checkOutput("jal_fu_pc", bus.fu_pc, 32'h100);
    checkOutput("jal_fu_imm", bus.fu_imm, 32'h20);
    checkOutput("jal_busy_ready", bus.issue_ready, 0);
    tick;
    checkOutput("jal_fu_en_low", bus.fu_en, 0);
    tick;
    checkOutput("jal_redirect", bus.redirect_valid, 1);
    checkOutput("jal_redirect_pc", bus.redirect_pc, 32'h120);
    checkOutput("jal_wb_valid", bus.wb_valid, 1);
    checkOutput("jal_wb_rd", bus.wb_rd, 1);
    checkOutput("jal_wb_data", bus.wb_data, 32'h104);
    checkOutput("jal_wb_tag", bus.wb_tag, 3);
    tick;
    checkOutput("jal_redirect_pulse", bus.redirect_valid, 0);
    checkOutput("jal_idle_ready", bus.issue_ready, 1);

    // BEQ rs1=5 rs2=6: not taken
    applyStimulus(1'b0, 1'b0, CMP_BEQ, 32'd5, 32'd6, 32'h40, 32'h180, 5'd7, 4'd1);
    tick; bus.issue_valid = 1'b0;
    checkOutput("beq_fu_cmp", bus.fu_cmp_ctrl, CMP_BEQ);
    checkOutput("beq_fu_rs2", bus.fu_rs2_data, 32'd6);
    tick; tick;
    checkOutput("beq_redirect", bus.redirect_valid, 0);
    checkOutput("beq_wb_valid", bus.wb_valid, 0);
    tick;
    checkOutput("beq_ready_n4", bus.issue_ready, 1);

    // BNE rs1=5 rs2=6: taken, no writeback
    applyStimulus(1'b0, 1'b0, CMP_BNE, 32'd5, 32'd6, 32'h40, 32'h180, 5'd7, 4'd1);
    tick; bus.issue_valid = 1'b0;
    tick; tick;
    checkOutput("bne_redirect", bus.redirect_valid, 1);
    checkOutput("bne_redirect_pc", bus.redirect_pc, 32'h1c0);
    checkOutput("bne_wb_valid", bus.wb_valid, 0);
    tick;

    // JALR rs1=0x203 imm=0 rd=0
    applyStimulus(1'b1, 1'b1, CMP_BEQ, 32'h203, 32'h0, 32'h0, 32'h500, 5'd0, 4'd2);
    tick; bus.issue_valid = 1'b0;
    tick; tick;
    checkOutput("jalr_redirect", bus.redirect_valid, 1);
    checkOutput("jalr_redirect_pc", bus.redirect_pc, 32'h202);
    checkOutput("jalr_wb_valid", bus.wb_valid, 0);
    tick;
    checkOutput("jalr_busy", busy, 0);

    // JAL with wb_ready low for three cycles
    bus.wb_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, CMP_BEQ, 32'h0, 32'h0, 32'h40, 32'h200, 5'd3, 4'd5);
    tick; bus.issue_valid = 1'b0;
    tick; tick;
    checkOutput("stall_redirect", bus.redirect_valid, 1);
    checkOutput("stall_wb_valid0", bus.wb_valid, 1);
    tick;
    checkOutput("stall_wb_valid1", bus.wb_valid, 1);
    checkOutput("stall_redirect_pulse", bus.redirect_valid, 0);
    checkOutput("stall_wb_data1", bus.wb_data, 32'h204);
    checkOutput("stall_ready1", bus.issue_ready, 0);
    tick;
    checkOutput("stall_wb_valid2", bus.wb_valid, 1);
    checkOutput("stall_wb_data2", bus.wb_data, 32'h204);
    checkOutput("stall_wb_rd2", bus.wb_rd, 3);
    checkOutput("stall_wb_tag2", bus.wb_tag, 5);
    tick;
    bus.wb_ready = 1'b1; #1;
    checkOutput("stall_wb_valid3", bus.wb_valid, 1);
    tick;
    checkOutput("stall_done_busy", busy, 0);
    checkOutput("stall_done_wb", bus.wb_valid, 0);
    checkOutput("stall_done_ready", bus.issue_ready, 1);

    // flush in WAIT together with fu_finish
    applyStimulus(1'b0, 1'b1, CMP_BEQ, 32'h0, 32'h0, 32'h8, 32'h300, 5'd2, 4'd6);
    tick; bus.issue_valid = 1'b0;
    tick;
    flush = 1'b1; #1;
    checkOutput("flush_wait_redirect", bus.redirect_valid, 0);
    tick; flush = 1'b0; #1;
    checkOutput("flush_wait_busy", busy, 0);
    checkOutput("flush_wait_redirect2", bus.redirect_valid, 0);
    checkOutput("flush_wait_wb", bus.wb_valid, 0);
    applyStimulus(1'b0, 1'b1, CMP_BEQ, 32'h0, 32'h0, 32'h10, 32'h400, 5'd4, 4'd7);
    tick; bus.issue_valid = 1'b0;
    tick; tick;
    checkOutput("post_flush_redirect", bus.redirect_valid, 1);
    checkOutput("post_flush_pc", bus.redirect_pc, 32'h410);
    checkOutput("post_flush_wb_data", bus.wb_data, 32'h404);
    checkOutput("post_flush_wb_rd", bus.wb_rd, 4);
    tick;

    // flush in IDLE blocks the issue; flush in ISSUE kills fu_en
    flush = 1'b1;
    applyStimulus(1'b0, 1'b1, CMP_BEQ, 32'h0, 32'h0, 32'h4, 32'h600, 5'd5, 4'd8);
    checkOutput("flush_idle_ready", bus.issue_ready, 0);
    tick;
    checkOutput("flush_idle_busy", busy, 0);
    flush = 1'b0; #1;
    tick; bus.issue_valid = 1'b0;
    flush = 1'b1; #1;
    checkOutput("flush_issue_fu_en", bus.fu_en, 0);
    tick; flush = 1'b0; #1;
    checkOutput("flush_issue_busy", busy, 0);
    tick;
    checkOutput("flush_issue_redirect", bus.redirect_valid, 0);

    // FU never finishes: timeout after 8 WAIT cycles
    fu_mute = 1'b1;
    checkOutput("pre_timeout_err", err_timeout, 0);
    applyStimulus(1'b0, 1'b1, CMP_BEQ, 32'h0, 32'h0, 32'h4, 32'h700, 5'd5, 4'd8);
    tick; bus.issue_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      checkOutput($sformatf("timeout_wait_busy%0d", i), busy, 1);
    end
    checkOutput("timeout_err_late", err_timeout, 0);
    tick;
    checkOutput("timeout_err", err_timeout, 1);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_redirect", bus.redirect_valid, 0);
    fu_mute = 1'b0;
    tick;
    checkOutput("timeout_sticky", err_timeout, 1);

    // reset asserted while waiting in WB
    bus.wb_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, CMP_BEQ, 32'h0, 32'h0, 32'h4, 32'h800, 5'd6, 4'd9);
    tick; bus.issue_valid = 1'b0;
    tick; tick; tick;
    checkOutput("rstwb_wb_valid", bus.wb_valid, 1);
    rst_n = 1'b0; #1;
    checkOutput("rstwb_wb_valid0", bus.wb_valid, 0);
    checkOutput("rstwb_wb_data", bus.wb_data, 0);
    checkOutput("rstwb_busy", busy, 0);
    checkOutput("rstwb_err", err_timeout, 0);
    checkOutput("rstwb_issue_ready", bus.issue_ready, 0);
    checkOutput("rstwb_redirect", bus.redirect_valid, 0);
    tick;
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    tick;
    checkOutput("rstwb_ready_after", bus.issue_ready, 1);
    checkOutput("rstwb_wb_after", bus.wb_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
